// File: rtl/serv_dbus_ram.sv
// Wishbone classic data RAM: word-addressed, byte-lane writes, full-word reads.
// Latency: ack in the cycle after capture plus WAIT wait-state cycles; one idle cycle follows every ack.
// Backpressure: none; one request is accepted per WAIT+2 cycles, and dropping cyc during wait states aborts.
module serv_dbus_ram #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic [31:0] i_wb_adr,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_dat,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_rdt
);

   localparam int WORDS = DEPTH / 4;
   localparam int AW    = $clog2(WORDS);
   // A single-word RAM still needs a one-bit index; the mask keeps it at zero.
   localparam int IW    = (AW > 0) ? AW : 1;
   localparam logic [IW-1:0] IDX_MASK = IW'(WORDS - 1);
   localparam logic [3:0]    WAIT_CNT = 4'(WAIT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [31:0]   mem [0:WORDS-1];

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q,   cnt_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic          we_q,    we_d;
   logic [3:0]    sel_q,   sel_d;
   logic [31:0]   dat_q,   dat_d;
   logic [31:0]   rdt_q,   rdt_d;
   logic [IW-1:0] adr_idx;

   // Upper address bits and byte offset are deliberately ignored (address wraps modulo DEPTH).
   logic unused_adr;
   assign unused_adr = ^{i_wb_adr[31:IW+2], i_wb_adr[1:0]};

   assign adr_idx  = i_wb_adr[IW+1:2] & IDX_MASK;
   assign o_wb_ack = (state_q == S_ACK);
   assign o_wb_rdt = rdt_q;

   // Next-state logic: capture request in IDLE, count wait states, load read data when entering ACK.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      rdt_d   = rdt_q;
      case (state_q)
         S_IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               idx_d = adr_idx;
               we_d  = i_wb_we;
               sel_d = i_wb_sel;
               dat_d = i_wb_dat;
               cnt_d = WAIT_CNT;
               if (WAIT > 0) begin
                  state_d = S_WAIT;
               end else begin
                  // Zero wait states: the index is captured on this same edge, so read via the live address.
                  state_d = S_ACK;
                  if (!i_wb_we) rdt_d = mem[adr_idx];
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               // Master gave up the cycle: drop the transfer without acking or writing.
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_ACK;
                  if (!we_q) rdt_d = mem[idx_q];
               end
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and request registers; reset cancels any transfer in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         dat_q   <= 32'h0;
         rdt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         rdt_q   <= rdt_d;
      end
   end

   // Byte-lane write on the edge leaving ACK; reset forces IDLE asynchronously, which suppresses it.
   always_ff @(posedge i_clk) begin
      if (state_q == S_ACK && we_q) begin
         for (int n = 0; n < 4; n++) begin
            if (sel_q[n]) mem[idx_q][8*n +: 8] <= dat_q[8*n +: 8];
         end
      end
   end

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: one instance with WAIT=0 and one with WAIT=3, DEPTH=256.
// Vector table of transfers plus hand sequences for reset, back-to-back, abort and reset-in-ACK.
// Read results are predicted at issue time, queued, and compared when the ack arrives.
module tb_serv_dbus_ram;

   logic        clk;
   logic        rst_n;
   logic [1:0]  cyc, stb, we, ack;
   logic [31:0] adr [2];
   logic [31:0] dat [2];
   logic [31:0] rdt [2];
   logic [3:0]  sel [2];

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_rd [2];

   typedef struct packed {
      logic        d;
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [$];

   serv_dbus_ram #(.DEPTH(256), .WAIT(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
      .i_wb_adr(adr[0]), .i_wb_we(we[0]), .i_wb_sel(sel[0]), .i_wb_dat(dat[0]),
      .o_wb_ack(ack[0]), .o_wb_rdt(rdt[0])
   );

   serv_dbus_ram #(.DEPTH(256), .WAIT(3)) u3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
      .i_wb_adr(adr[1]), .i_wb_we(we[1]), .i_wb_sel(sel[1]), .i_wb_dat(dat[1]),
      .o_wb_ack(ack[1]), .o_wb_rdt(rdt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transfer on instance d, starting and ending at a negedge in IDLE.
   task automatic xfer(input int d, input logic we_v, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dv, input logic [31:0] exp_rd, input string name);
      int lat;
      bit got;
      int wt;
      wt = (d == 0) ? 0 : 3;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = we_v; adr[d] = a; sel[d] = s; dat[d] = dv;
      if (!we_v) exp_q.push_back(exp_rd);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         got = ack[d];
         if (lat == 1) begin
            // Request is captured; the DUT must ignore these changes.
            we[d] = ~we_v; adr[d] = ~a; sel[d] = ~s; dat[d] = ~dv;
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: no ack within 20 cycles", name);
         if (!we_v) void'(exp_q.pop_front());
      end else begin
         chk({name, " latency"}, 32'(lat), 32'(wt + 1));
         if (!we_v) begin
            last_rd[d] = exp_q.pop_front();
            chk({name, " rdt"}, rdt[d], last_rd[d]);
         end else begin
            chk({name, " rdt hold"}, rdt[d], last_rd[d]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk({name, " ack one cycle"}, {31'd0, ack[d]}, 32'd0);
   endtask

   initial begin
      logic [31:0] obs, expm;
      int lat [2];
      bit got;

      rst_n = 1'b0;
      cyc = 2'b11; stb = 2'b11; we = 2'b11;
      adr[0] = 32'h0;  dat[0] = 32'hA5A5A5A5; sel[0] = 4'hF;
      adr[1] = 32'h3C; dat[1] = 32'h5A5A5A5A; sel[1] = 4'hF;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;

      // Reset held with requests pending: outputs stay quiet.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ack d%0d c%0d", d, c), {31'd0, ack[d]}, 32'd0);
            chk($sformatf("reset rdt d%0d c%0d", d, c), rdt[d], 32'h0);
         end
      end

      // Release: first capture on the first edge with reset high.
      rst_n = 1'b1;
      lat[0] = 0;
      lat[1] = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (ack[d] && lat[d] == 0) begin
               lat[d] = c;
               cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            end
         end
      end
      chk("post-reset latency d0", 32'(lat[0]), 32'd1);
      chk("post-reset latency d1", 32'(lat[1]), 32'd4);
      cyc = 2'b00; stb = 2'b00; we = 2'b00;

      tbl.push_back('{1'b0, 1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0});
      tbl.push_back('{1'b0, 1'b0, 32'h010, 4'hF, 32'h0,        32'hDEADBEEF});
      tbl.push_back('{1'b0, 1'b1, 32'h020, 4'hF, 32'h00000000, 32'h0});
      tbl.push_back('{1'b0, 1'b1, 32'h020, 4'h5, 32'h11223344, 32'h0});
      tbl.push_back('{1'b0, 1'b0, 32'h020, 4'h3, 32'h0,        32'h00220044});
      tbl.push_back('{1'b0, 1'b1, 32'h020, 4'h0, 32'hFFFFFFFF, 32'h0});
      tbl.push_back('{1'b0, 1'b0, 32'h020, 4'h0, 32'h0,        32'h00220044});
      tbl.push_back('{1'b0, 1'b1, 32'h104, 4'hF, 32'hCAFEF00D, 32'h0});
      tbl.push_back('{1'b0, 1'b0, 32'h004, 4'hF, 32'h0,        32'hCAFEF00D});
      tbl.push_back('{1'b0, 1'b0, 32'h107, 4'hF, 32'h0,        32'hCAFEF00D});
      tbl.push_back('{1'b0, 1'b0, 32'h000, 4'hF, 32'h0,        32'hA5A5A5A5});
      tbl.push_back('{1'b1, 1'b1, 32'h008, 4'hF, 32'h13572468, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 32'h008, 4'hF, 32'h0,        32'h13572468});
      tbl.push_back('{1'b1, 1'b0, 32'h13C, 4'hF, 32'h0,        32'h5A5A5A5A});
      tbl.push_back('{1'b1, 1'b1, 32'h018, 4'hF, 32'h12345678, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 32'h008, 4'h8, 32'hEE000000, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 32'h008, 4'hF, 32'h0,        32'hEE572468});

      for (int i = 0; i < tbl.size(); i++) begin
         xfer(int'(tbl[i].d), tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].exp,
              $sformatf("vec%0d", i));
      end

      // Back-to-back reads with stb held: one ack per WAIT+2 cycles.
      for (int d = 0; d < 2; d++) begin
         int n;
         n = (d == 0) ? 8 : 15;
         cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; sel[d] = 4'hF;
         adr[d] = (d == 0) ? 32'h10 : 32'h8;
         obs = 32'h0;
         expm = 32'h0;
         for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            obs[c] = ack[d];
            expm[c] = (d == 0) ? (c % 2 == 1) : (c % 5 == 4);
         end
         cyc[d] = 1'b0; stb[d] = 1'b0;
         chk($sformatf("b2b ack pattern d%0d", d), obs, expm);
         last_rd[d] = (d == 0) ? 32'hDEADBEEF : 32'hEE572468;
         chk($sformatf("b2b rdt d%0d", d), rdt[d], last_rd[d]);
         @(negedge clk);
      end

      // Abort: drop cyc during wait states on the WAIT=3 instance.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h8; sel[1] = 4'hF; dat[1] = 32'hFFFFFFFF;
      obs = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         obs[0] = obs[0] | ack[1];
         if (c == 2) cyc[1] = 1'b0;
      end
      stb[1] = 1'b0; we[1] = 1'b0;
      chk("abort no ack", obs, 32'h0);
      xfer(1, 1'b0, 32'h8, 4'hF, 32'h0, 32'hEE572468, "abort no write");

      // Reset during the ACK cycle of a write: the write must not land.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h18; sel[1] = 4'hF; dat[1] = 32'hFFFFFFFF;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(posedge clk);
         @(negedge clk);
         got = ack[1];
      end
      chk("rst-in-ack reached ack", {31'd0, got}, 32'd1);
      rst_n = 1'b0;
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      #1;
      chk("rst-in-ack ack", {31'd0, ack[1]}, 32'd0);
      chk("rst-in-ack rdt", rdt[1], 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      @(negedge clk);
      xfer(1, 1'b0, 32'h18, 4'hF, 32'h0, 32'h12345678, "rst-in-ack no write");
      xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h00220044, "post-reset d0 read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
